// File: rtl/rfblackwidow_gp_wb_sched.sv
// Writeback scheduler for the general-purpose register file.
// Four result buses feed small FIFOs. Each cycle up to three FIFO heads are
// picked oldest-first by sequence tag and sent to write ports 0..2 in age
// order. The youngest result therefore lands on the highest-numbered active
// port, which is the port that wins a same-register write or bypass.
module rfblackwidow_gp_wb_sched #(
    parameter int WID   = 64,
    parameter int TAGW  = 8,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        src_v,
    output logic [3:0]        src_rdy,
    input  logic [4*TAGW-1:0] src_tag,
    input  logic [4*6-1:0]    src_rd,
    input  logic [4*WID-1:0]  src_val,
    output logic              wr0,
    output logic              wr1,
    output logic              wr2,
    output logic [5:0]        wa0,
    output logic [5:0]        wa1,
    output logic [5:0]        wa2,
    output logic [WID-1:0]    i0,
    output logic [WID-1:0]    i1,
    output logic [WID-1:0]    i2,
    output logic              busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Head of each source FIFO; these are the only scheduling candidates.
    logic [TAGW-1:0] head_tag [4];
    logic [5:0]      head_rd  [4];
    logic [WID-1:0]  head_val [4];
    logic [3:0]      cand;
    logic [3:0]      push;
    logic [3:0]      pop;
    logic [CW-1:0]   count_next [4];

    // Age compare with wrap-around; equal tags fall back to source index.
    function automatic logic is_older(input logic [TAGW-1:0] a,
                                      input logic [TAGW-1:0] b,
                                      input logic a_lower_idx);
        logic [TAGW-1:0] diff;
        diff = a - b;
        return diff[TAGW-1] || ((a == b) && a_lower_idx);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fifo
            logic [TAGW-1:0] tag_mem [DEPTH];
            logic [5:0]      rd_mem  [DEPTH];
            logic [WID-1:0]  val_mem [DEPTH];
            logic [AW-1:0]   wr_ptr_reg;
            logic [AW-1:0]   rd_ptr_reg;
            logic [CW-1:0]   count_reg;

            // Ready depends only on the registered count (a same-cycle pop
            // never frees a slot early) and is held low during reset.
            assign src_rdy[gi]    = rst_n && (count_reg != CW'(DEPTH));
            assign push[gi]       = src_v[gi] && src_rdy[gi];
            assign cand[gi]       = (count_reg != '0);
            assign head_tag[gi]   = tag_mem[rd_ptr_reg];
            assign head_rd[gi]    = rd_mem[rd_ptr_reg];
            assign head_val[gi]   = val_mem[rd_ptr_reg];
            assign count_next[gi] = count_reg + CW'(push[gi]) - CW'(pop[gi]);

            // Storage write on accept; contents need no reset.
            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    tag_mem[wr_ptr_reg] <= src_tag[gi*TAGW +: TAGW];
                    rd_mem[wr_ptr_reg]  <= src_rd[gi*6 +: 6];
                    val_mem[wr_ptr_reg] <= src_val[gi*WID +: WID];
                end
            end

            // Pointer and occupancy update; reset discards everything queued.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) wr_ptr_reg <= wr_ptr_reg + AW'(1);
                    if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + AW'(1);
                    count_reg <= count_next[gi];
                end
            end
        end
    endgenerate

    logic [1:0]     rank [4];
    logic [2:0]     slot_v;
    logic [5:0]     slot_rd  [3];
    logic [WID-1:0] slot_val [3];
    logic           busy_next;

    // Rank every head by age, pop the three oldest and place them in slots
    // 0..2 in age order. Ranks are distinct among valid heads.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rank[i] = '0;
            for (int j = 0; j < 4; j++) begin
                if (j != i && cand[j] && is_older(head_tag[j], head_tag[i], j < i))
                    rank[i] = rank[i] + 2'd1;
            end
        end
        pop = '0;
        for (int i = 0; i < 4; i++)
            pop[i] = cand[i] && (rank[i] != 2'd3);
        slot_v = '0;
        for (int k = 0; k < 3; k++) begin
            slot_rd[k]  = '0;
            slot_val[k] = '0;
            for (int i = 0; i < 4; i++) begin
                if (pop[i] && rank[i] == 2'(k)) begin
                    slot_v[k]   = 1'b1;
                    slot_rd[k]  = head_rd[i];
                    slot_val[k] = head_val[i];
                end
            end
        end
        busy_next = 1'b0;
        for (int s = 0; s < 4; s++)
            if (count_next[s] != '0) busy_next = 1'b1;
        for (int k = 0; k < 3; k++)
            if (slot_v[k] && slot_rd[k] != 6'd0) busy_next = 1'b1;
    end

    logic           wr_reg [3];
    logic [5:0]     wa_reg [3];
    logic [WID-1:0] i_reg  [3];
    logic           busy_reg;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_port
            // Register one write port; r0 results consume the slot but do not
            // write, and an empty slot keeps its previous address and data.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    wr_reg[gi] <= 1'b0;
                    wa_reg[gi] <= '0;
                    i_reg[gi]  <= '0;
                end else begin
                    wr_reg[gi] <= slot_v[gi] && (slot_rd[gi] != 6'd0);
                    if (slot_v[gi]) begin
                        wa_reg[gi] <= slot_rd[gi];
                        i_reg[gi]  <= slot_val[gi];
                    end
                end
            end
        end
    endgenerate

    // Busy reflects pending work left behind by this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) busy_reg <= 1'b0;
        else        busy_reg <= busy_next;
    end

    assign wr0  = wr_reg[0];
    assign wr1  = wr_reg[1];
    assign wr2  = wr_reg[2];
    assign wa0  = wa_reg[0];
    assign wa1  = wa_reg[1];
    assign wa2  = wa_reg[2];
    assign i0   = i_reg[0];
    assign i1   = i_reg[1];
    assign i2   = i_reg[2];
    assign busy = busy_reg;

endmodule

// File: tb/tb_rfblackwidow_gp_wb_sched.sv
// Scoreboard bench for the writeback scheduler: stimulus pushes expected
// write cycles into a queue, a negedge monitor pops and compares them.
module tb_rfblackwidow_gp_wb_sched;

    localparam int WID   = 64;
    localparam int TAGW  = 8;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       src_v = '0;
    logic [3:0]       src_rdy;
    logic [4*TAGW-1:0] src_tag = '0;
    logic [23:0]      src_rd = '0;
    logic [4*WID-1:0] src_val = '0;
    logic             wr0, wr1, wr2;
    logic [5:0]       wa0, wa1, wa2;
    logic [WID-1:0]   i0, i1, i2;
    logic             busy;

    rfblackwidow_gp_wb_sched #(.WID(WID), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_v(src_v), .src_rdy(src_rdy),
        .src_tag(src_tag), .src_rd(src_rd), .src_val(src_val),
        .wr0(wr0), .wr1(wr1), .wr2(wr2),
        .wa0(wa0), .wa1(wa1), .wa2(wa2),
        .i0(i0), .i1(i1), .i2(i2),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]   wr;
        logic [17:0]  wa;
        logic [191:0] iv;
    } wexp_t;

    wexp_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    function automatic wexp_t mk(input logic [2:0] wr,
                                 input logic [5:0] a0, input logic [63:0] v0,
                                 input logic [5:0] a1, input logic [63:0] v1,
                                 input logic [5:0] a2, input logic [63:0] v2);
        wexp_t e;
        e.wr = wr;
        e.wa = {a2, a1, a0};
        e.iv = {v2, v1, v0};
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end else begin
            $display("check %s: %0h ok", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic [7:0] tag, input logic [5:0] rd,
                           input logic [63:0] val);
        src_tag[s*TAGW +: TAGW] = tag;
        src_rd[s*6 +: 6]        = rd;
        src_val[s*WID +: WID]   = val;
    endtask

    // Monitor: every cycle with a write enable must match the next expected entry.
    wexp_t mon_e;
    logic  mon_ok;
    always @(negedge clk) begin
        if (rst_n && (wr0 || wr1 || wr2)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: wr=%b wa=%0d/%0d/%0d i=%0h/%0h/%0h required no write",
                         {wr2, wr1, wr0}, wa0, wa1, wa2, i0, i1, i2);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_ok = ({wr2, wr1, wr0} == mon_e.wr);
                if (mon_e.wr[0]) mon_ok = mon_ok && (wa0 == mon_e.wa[5:0])   && (i0 == mon_e.iv[63:0]);
                if (mon_e.wr[1]) mon_ok = mon_ok && (wa1 == mon_e.wa[11:6])  && (i1 == mon_e.iv[127:64]);
                if (mon_e.wr[2]) mon_ok = mon_ok && (wa2 == mon_e.wa[17:12]) && (i2 == mon_e.iv[191:128]);
                if (!mon_ok) begin
                    errors++;
                    $display("FAIL write_txn: got wr=%b wa=%0d/%0d/%0d i=%0h/%0h/%0h required wr=%b wa=%0d/%0d/%0d i=%0h/%0h/%0h",
                             {wr2, wr1, wr0}, wa0, wa1, wa2, i0, i1, i2,
                             mon_e.wr, mon_e.wa[5:0], mon_e.wa[11:6], mon_e.wa[17:12],
                             mon_e.iv[63:0], mon_e.iv[127:64], mon_e.iv[191:128]);
                end else begin
                    $display("write wr=%b wa=%0d/%0d/%0d i=%0h/%0h/%0h ok",
                             {wr2, wr1, wr0}, wa0, wa1, wa2, i0, i1, i2);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_rdy", 64'(src_rdy), 64'h0);
        chk("rst_wr", 64'({wr2, wr1, wr0}), 64'h0);
        chk("rst_wa", 64'({wa2, wa1, wa0}), 64'h0);
        chk("rst_i0", i0, 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("idle_rdy", 64'(src_rdy), 64'hF);
        chk("idle_busy", 64'(busy), 64'h0);

        // Single push on source 2: port 0 only, two cycles after accept
        tick();
        set_src(2, 8'd5, 6'd7, 64'h1234);
        src_v = 4'b0100;
        exp_q.push_back(mk(3'b001, 6'd7, 64'h1234, 6'd0, 64'h0, 6'd0, 64'h0));
        tick();
        src_v = '0;
        @(negedge clk);
        chk("lat_no_early_wr", 64'({wr2, wr1, wr0}), 64'h0);
        chk("lat_busy", 64'(busy), 64'h1);
        repeat (3) tick();
        @(negedge clk);
        chk("single_drained_busy", 64'(busy), 64'h0);

        // Four sources at once: tags 10,3,7,12
        tick();
        set_src(0, 8'd10, 6'd1, 64'h100A);
        set_src(1, 8'd3,  6'd2, 64'h1003);
        set_src(2, 8'd7,  6'd3, 64'h1007);
        set_src(3, 8'd12, 6'd4, 64'h100C);
        src_v = 4'b1111;
        exp_q.push_back(mk(3'b111, 6'd2, 64'h1003, 6'd3, 64'h1007, 6'd1, 64'h100A));
        exp_q.push_back(mk(3'b001, 6'd4, 64'h100C, 6'd0, 64'h0, 6'd0, 64'h0));
        tick();
        src_v = '0;
        repeat (4) tick();

        // Tag wrap: 0xFE older than 0x01, same destination r9
        set_src(0, 8'hFE, 6'd9, 64'hAAAA);
        set_src(3, 8'h01, 6'd9, 64'hBBBB);
        src_v = 4'b1001;
        exp_q.push_back(mk(3'b011, 6'd9, 64'hAAAA, 6'd9, 64'hBBBB, 6'd0, 64'h0));
        tick();
        src_v = '0;
        repeat (4) tick();

        // r0 result on src1 consumes slot 1 without writing
        set_src(0, 8'h20, 6'd4, 64'h44);
        set_src(1, 8'h21, 6'd0, 64'h55);
        src_v = 4'b0011;
        exp_q.push_back(mk(3'b001, 6'd4, 64'h44, 6'd0, 64'h0, 6'd0, 64'h0));
        tick();
        src_v = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("rd0_both_popped_busy", 64'(busy), 64'h0);

        // Back-pressure on src0 behind three older r0 streams, then reset mid-burst
        tick();
        set_src(0, 8'd100, 6'd5, 64'h5555);
        set_src(1, 8'd10,  6'd0, 64'h1);
        set_src(2, 8'd11,  6'd0, 64'h2);
        set_src(3, 8'd12,  6'd0, 64'h3);
        src_v = 4'b1111;
        for (int k = 0; k < DEPTH + 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_rdy0_c%0d", k), 64'(src_rdy[0]), (k < DEPTH) ? 64'h1 : 64'h0);
            tick();
        end
        @(negedge clk);
        chk("bp_busy", 64'(busy), 64'h1);
        tick();
        rst_n = 1'b0;
        src_v = '0;
        tick();
        @(negedge clk);
        chk("midrst_wr", 64'({wr2, wr1, wr0}), 64'h0);
        chk("midrst_busy", 64'(busy), 64'h0);
        chk("midrst_rdy", 64'(src_rdy), 64'h0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'h0);
        chk("post_rst_rdy", 64'(src_rdy), 64'hF);

        tick();
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
